// File: rtl/svm_sample_sequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : svm_sample_sequencer
// Brief    : Streams labelled samples through the SVM classifier and scores it.
// Revision : 1.0
// ----------------------------------------------------------------------------
module svm_sample_sequencer #(
  parameter int N_features = 17,
  parameter int inputWidth = 4,
  parameter int classWidth = 4,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 1023
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [N_features*inputWidth-1:0] s_sample,
  input  logic [classWidth-1:0]            s_label,
  output logic [N_features*inputWidth-1:0] clf_in,
  output logic                             clf_rst_n,
  input  logic                             clf_ready,
  input  logic [classWidth-1:0]            clf_class,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [classWidth-1:0]            res_class,
  output logic [classWidth-1:0]            res_label,
  output logic                             res_match,
  output logic                             res_timeout,
  input  logic                             stat_clear,
  output logic [CNT_W-1:0]                 stat_total,
  output logic [CNT_W-1:0]                 stat_correct
);

  localparam int c_SW    = N_features * inputWidth;
  localparam int c_TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_LOAD   = 2'd1;
  localparam logic [1:0] c_RUN    = 2'd2;
  localparam logic [1:0] c_REPORT = 2'd3;

  logic [1:0]            r_state;
  logic [c_SW-1:0]       r_clf_in;
  logic [classWidth-1:0] r_label;
  logic                  r_clf_rst_n;
  logic                  r_rdy_q;
  logic [c_TMR_W-1:0]    r_tmr;
  logic [classWidth-1:0] r_res_class;
  logic                  r_res_match;
  logic                  r_res_timeout;
  logic [CNT_W-1:0]      r_total;
  logic [CNT_W-1:0]      r_correct;

  logic w_done;
  logic w_hs;

  // A ready level carried over from the previous sample must not count, so only a rising edge completes.
  assign w_done = clf_ready && !r_rdy_q;
  assign w_hs   = (r_state == c_REPORT) && res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= c_IDLE;
      r_clf_in      <= '0;
      r_label       <= '0;
      r_clf_rst_n   <= 1'b0;
      r_rdy_q       <= 1'b1;
      r_tmr         <= '0;
      r_res_class   <= '0;
      r_res_match   <= 1'b0;
      r_res_timeout <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (s_valid) begin
            r_clf_in    <= s_sample;
            r_label     <= s_label;
            r_clf_rst_n <= 1'b0;
            r_state     <= c_LOAD;
          end
        end
        c_LOAD: begin
          r_rdy_q     <= 1'b1;
          r_tmr       <= '0;
          r_clf_rst_n <= 1'b1;
          r_state     <= c_RUN;
        end
        c_RUN: begin
          r_rdy_q <= clf_ready;
          if (w_done) begin
            r_res_class   <= clf_class;
            r_res_match   <= (clf_class == r_label);
            r_res_timeout <= 1'b0;
            r_state       <= c_REPORT;
          end else if (r_tmr == c_TMR_W'(TIMEOUT)) begin
            r_res_class   <= '0;
            r_res_match   <= 1'b0;
            r_res_timeout <= 1'b1;
            r_state       <= c_REPORT;
          end else begin
            r_tmr <= r_tmr + c_TMR_W'(1);
          end
        end
        default: begin
          if (res_ready) begin
            r_state <= c_IDLE;
          end
        end
      endcase
    end
  end

  // Clear takes priority over a coincident report handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_total   <= '0;
      r_correct <= '0;
    end else if (stat_clear) begin
      r_total   <= '0;
      r_correct <= '0;
    end else if (w_hs) begin
      if (r_total != {CNT_W{1'b1}}) begin
        r_total <= r_total + CNT_W'(1);
      end
      if (r_res_match && (r_correct != {CNT_W{1'b1}})) begin
        r_correct <= r_correct + CNT_W'(1);
      end
    end
  end

  assign s_ready      = (r_state == c_IDLE) && !rst;
  assign clf_in       = r_clf_in;
  assign clf_rst_n    = r_clf_rst_n;
  assign res_valid    = (r_state == c_REPORT);
  assign res_class    = r_res_class;
  assign res_label    = r_label;
  assign res_match    = r_res_match;
  assign res_timeout  = r_res_timeout;
  assign stat_total   = r_total;
  assign stat_correct = r_correct;

endmodule
`default_nettype wire

// File: tb/tb_svm_sample_sequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_svm_sample_sequencer
// Brief    : Self-checking bench; unit 0 uses defaults, unit 1 TIMEOUT=8, CNT_W=2.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_svm_sample_sequencer;

  localparam int c_TO0   = 1023;
  localparam int c_TO1   = 8;
  localparam int c_NEVER = 1000000;

  typedef struct {
    int          d;
    logic [67:0] sample;
    logic [3:0]  label;
    int          lat;
    logic [3:0]  cls;
    logic        stale;
    int          hold;
    logic        clr;
    logic [3:0]  e_class;
    logic        e_match;
    logic        e_to;
    int          e_cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s_valid     [2];
  logic        s_ready     [2];
  logic [67:0] s_sample    [2];
  logic [3:0]  s_label     [2];
  logic [67:0] clf_in      [2];
  logic        clf_rst_n   [2];
  logic        clf_ready   [2];
  logic [3:0]  clf_class   [2];
  logic        res_valid   [2];
  logic        res_ready   [2];
  logic [3:0]  res_class   [2];
  logic [3:0]  res_label   [2];
  logic        res_match   [2];
  logic        res_timeout [2];
  logic        stat_clear  [2];
  logic [15:0] tot0, cor0;
  logic [1:0]  tot1, cor1;

  svm_sample_sequencer u_dut0 (
    .clk(clk), .rst(rst), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .s_sample(s_sample[0]), .s_label(s_label[0]), .clf_in(clf_in[0]),
    .clf_rst_n(clf_rst_n[0]), .clf_ready(clf_ready[0]), .clf_class(clf_class[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_class(res_class[0]),
    .res_label(res_label[0]), .res_match(res_match[0]), .res_timeout(res_timeout[0]),
    .stat_clear(stat_clear[0]), .stat_total(tot0), .stat_correct(cor0)
  );

  svm_sample_sequencer #(.TIMEOUT(c_TO1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .s_sample(s_sample[1]), .s_label(s_label[1]), .clf_in(clf_in[1]),
    .clf_rst_n(clf_rst_n[1]), .clf_ready(clf_ready[1]), .clf_class(clf_class[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_class(res_class[1]),
    .res_label(res_label[1]), .res_match(res_match[1]), .res_timeout(res_timeout[1]),
    .stat_clear(stat_clear[1]), .stat_total(tot1), .stat_correct(cor1)
  );

  // Stub classifier: ready rises cfg_lat cycles after restart release; optional stale level early on.
  int         stub_k    [2];
  int         cfg_lat   [2];
  logic       cfg_stale [2];
  logic [3:0] cfg_cls   [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!clf_rst_n[i]) begin
        stub_k[i]    <= 0;
        clf_ready[i] <= cfg_stale[i];
      end else begin
        stub_k[i]    <= stub_k[i] + 1;
        clf_ready[i] <= (cfg_stale[i] && stub_k[i] == 0) || (stub_k[i] >= cfg_lat[i]);
      end
      clf_class[i] <= cfg_cls[i];
    end
  end

  int checks = 0;
  int errors = 0;
  int m_tot [2];
  int m_cor [2];
  vec_t vecs [8];

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] get_tot(input int d);
    return (d == 0) ? tot0 : {14'd0, tot1};
  endfunction

  function automatic logic [15:0] get_cor(input int d);
    return (d == 0) ? cor0 : {14'd0, cor1};
  endfunction

  function automatic int sat(input int v, input int d);
    int mx;
    mx = (d == 0) ? 65535 : 3;
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_stats(input int d, input string tag);
    chk({tag, "_total"}, get_tot(d), sat(m_tot[d], d));
    chk({tag, "_correct"}, get_cor(d), sat(m_cor[d], d));
  endtask

  // Reference: the result is the stub's class if its edge arrives within the timeout window.
  function automatic vec_t model(input int d, input logic [67:0] s, input logic [3:0] lab,
                                 input int lat, input logic [3:0] cls, input logic st,
                                 input int hold, input logic clr);
    vec_t v;
    bit   done;
    int   to;
    to   = (d == 0) ? c_TO0 : c_TO1;
    done = (lat >= (st ? 2 : 1)) && (lat <= to);
    v.d = d; v.sample = s; v.label = lab; v.lat = lat; v.cls = cls;
    v.stale = st; v.hold = hold; v.clr = clr;
    v.e_class = done ? cls : 4'd0;
    v.e_match = done && (cls == lab);
    v.e_to    = !done;
    v.e_cyc   = 3 + (done ? lat : to);
    return v;
  endfunction

  task automatic clear_stats(input int d);
    stat_clear[d] = 1'b1;
    @(negedge clk);
    stat_clear[d] = 1'b0;
    m_tot[d] = 0;
    m_cor[d] = 0;
    check_stats(d, "clear");
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int d;
    int n;
    d = v.d;
    cfg_lat[d]   = v.lat;
    cfg_stale[d] = v.stale;
    cfg_cls[d]   = v.cls;
    s_sample[d]  = v.sample;
    s_label[d]   = v.label;
    s_valid[d]   = 1'b1;
    n = 0;
    while (!s_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept_wait"}, n, 0);
    @(negedge clk);
    s_valid[d] = 1'b0;
    chk({tag, "_load_rst_n"}, clf_rst_n[d], 1'b0);
    chk({tag, "_load_s_ready"}, s_ready[d], 1'b0);
    chk({tag, "_clf_in"}, clf_in[d], v.sample);
    @(negedge clk);
    chk({tag, "_run_rst_n"}, clf_rst_n[d], 1'b1);
    n = 2;
    while (!res_valid[d] && n < 1100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, v.e_cyc);
    chk({tag, "_class"}, res_class[d], v.e_class);
    chk({tag, "_label"}, res_label[d], v.label);
    chk({tag, "_match"}, res_match[d], v.e_match);
    chk({tag, "_timeout"}, res_timeout[d], v.e_to);
    check_stats(d, {tag, "_pre"});
    for (int i = 0; i < v.hold; i++) begin
      s_valid[d]  = 1'b1;
      s_sample[d] = ~v.sample;
      @(negedge clk);
      chk({tag, "_bp_valid"}, res_valid[d], 1'b1);
      chk({tag, "_bp_class"}, res_class[d], v.e_class);
      chk({tag, "_bp_match"}, res_match[d], v.e_match);
      chk({tag, "_bp_s_ready"}, s_ready[d], 1'b0);
      chk({tag, "_bp_clf_in"}, clf_in[d], v.sample);
      check_stats(d, {tag, "_bp"});
    end
    res_ready[d]  = 1'b1;
    stat_clear[d] = v.clr;
    @(negedge clk);
    res_ready[d]  = 1'b0;
    stat_clear[d] = 1'b0;
    s_valid[d]    = 1'b0;
    if (v.clr) begin
      m_tot[d] = 0;
      m_cor[d] = 0;
    end else begin
      m_tot[d] = m_tot[d] + 1;
      m_cor[d] = m_cor[d] + (v.e_match ? 1 : 0);
    end
    chk({tag, "_post_valid"}, res_valid[d], 1'b0);
    chk({tag, "_post_s_ready"}, s_ready[d], 1'b1);
    check_stats(d, {tag, "_post"});
  endtask

  initial begin
    logic [95:0] r96;
    vec_t        v;
    int          d;
    logic [3:0]  lab;
    for (int i = 0; i < 2; i++) begin
      s_valid[i] = 1'b0; res_ready[i] = 1'b0; stat_clear[i] = 1'b0;
      s_sample[i] = '0; s_label[i] = '0;
      cfg_lat[i] = c_NEVER; cfg_stale[i] = 1'b0; cfg_cls[i] = '0;
      m_tot[i] = 0; m_cor[i] = 0;
    end

    vecs[0] = '{d:0, sample:68'h0_1234_5678_9ABC_DEF0, label:4'd3, lat:18, cls:4'd3, stale:1'b0,
                hold:0, clr:1'b0, e_class:4'd3, e_match:1'b1, e_to:1'b0, e_cyc:21};
    vecs[1] = '{d:0, sample:68'hA_5A5A_0F0F_3C3C_1111, label:4'd2, lat:6, cls:4'd7, stale:1'b1,
                hold:0, clr:1'b0, e_class:4'd7, e_match:1'b0, e_to:1'b0, e_cyc:9};
    vecs[2] = '{d:1, sample:68'h5_DEAD_BEEF_0000_7777, label:4'd5, lat:c_NEVER, cls:4'd5, stale:1'b0,
                hold:0, clr:1'b0, e_class:4'd0, e_match:1'b0, e_to:1'b1, e_cyc:11};
    vecs[3] = '{d:0, sample:68'h3_0102_0304_0506_0708, label:4'd9, lat:4, cls:4'd9, stale:1'b0,
                hold:10, clr:1'b0, e_class:4'd9, e_match:1'b1, e_to:1'b0, e_cyc:7};
    vecs[4] = '{d:0, sample:68'hF_FFFF_FFFF_FFFF_FFFF, label:4'd1, lat:1, cls:4'd1, stale:1'b0,
                hold:0, clr:1'b0, e_class:4'd1, e_match:1'b1, e_to:1'b0, e_cyc:4};
    vecs[5] = '{d:1, sample:68'h1_1111_2222_3333_4444, label:4'd4, lat:8, cls:4'd4, stale:1'b0,
                hold:0, clr:1'b0, e_class:4'd4, e_match:1'b1, e_to:1'b0, e_cyc:11};
    vecs[6] = '{d:1, sample:68'h2_2222_3333_4444_5555, label:4'd6, lat:9, cls:4'd6, stale:1'b0,
                hold:0, clr:1'b0, e_class:4'd0, e_match:1'b0, e_to:1'b1, e_cyc:11};
    vecs[7] = '{d:1, sample:68'h6_6666_7777_8888_9999, label:4'd2, lat:1, cls:4'd2, stale:1'b1,
                hold:1, clr:1'b0, e_class:4'd0, e_match:1'b0, e_to:1'b1, e_cyc:11};

    // Reset values while rst is held.
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_s_ready", s_ready[i], 1'b0);
      chk("rst_clf_rst_n", clf_rst_n[i], 1'b0);
      chk("rst_res_valid", res_valid[i], 1'b0);
      chk("rst_clf_in", clf_in[i], 68'd0);
      chk("rst_res_class", res_class[i], 4'd0);
      chk("rst_res_label", res_label[i], 4'd0);
      chk("rst_res_match", res_match[i], 1'b0);
      chk("rst_res_timeout", res_timeout[i], 1'b0);
      check_stats(i, "rst");
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle_s_ready", s_ready[0], 1'b1);

    for (int i = 0; i < 8; i++) begin
      if (i == 1) clear_stats(0);
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Randomised samples against the reference.
    for (int i = 0; i < 24; i++) begin
      d   = int'($urandom_range(0, 1));
      r96 = {$urandom, $urandom, $urandom};
      lab = 4'($urandom_range(0, 15));
      v = model(d, r96[67:0], lab, (d == 0) ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 12)),
                ($urandom_range(0, 1) == 1) ? lab : 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
      run_vec(v, $sformatf("rnd%0d", i));
    end

    // Ten samples, seven matching, clear on the last handshake.
    clear_stats(0);
    for (int i = 0; i < 10; i++) begin
      r96 = {$urandom, $urandom, $urandom};
      lab = 4'(i);
      v = model(0, r96[67:0], lab, int'($urandom_range(1, 10)), (i < 7) ? lab : lab + 4'd1,
                1'b0, 0, (i == 9));
      run_vec(v, $sformatf("clr%0d", i));
    end
    chk("clr_total_zero", get_tot(0), 16'd0);
    chk("clr_correct_zero", get_cor(0), 16'd0);

    // Two-bit counters saturate.
    clear_stats(1);
    for (int i = 0; i < 5; i++) begin
      r96 = {$urandom, $urandom, $urandom};
      v = model(1, r96[67:0], 4'd8, int'($urandom_range(1, 8)), 4'd8, 1'b0, 0, 1'b0);
      run_vec(v, $sformatf("sat%0d", i));
    end
    chk("sat_total", get_tot(1), 16'd3);
    chk("sat_correct", get_cor(1), 16'd3);

    // Asynchronous reset during RUN.
    v = model(0, 68'h7_0000_1111_2222_3333, 4'd5, 3, 4'd5, 1'b0, 0, 1'b0);
    run_vec(v, "pre_rst");
    cfg_lat[0] = c_NEVER;
    cfg_stale[0] = 1'b0;
    s_sample[0] = 68'h9_8765_4321_0FED_CBA9;
    s_valid[0] = 1'b1;
    @(negedge clk);
    s_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_res_valid", res_valid[0], 1'b0);
    chk("arst_clf_rst_n", clf_rst_n[0], 1'b0);
    chk("arst_s_ready", s_ready[0], 1'b0);
    chk("arst_total0", get_tot(0), 16'd0);
    chk("arst_correct0", get_cor(0), 16'd0);
    chk("arst_total1", get_tot(1), 16'd0);
    m_tot[0] = 0; m_cor[0] = 0; m_tot[1] = 0; m_cor[1] = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    v = model(0, 68'hC_CCCC_DDDD_EEEE_FFFF, 4'd12, 5, 4'd12, 1'b0, 0, 1'b0);
    run_vec(v, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
